divider_pipe: RTL
=================

Name: divider_pipe

Overview:
- Fully pipelined unsigned restoring divider; computes dividend / divisor for arbitrary N-bit dividend and M-bit divisor.
- One quotient bit is resolved per stage; N stages; one new operation can be accepted every cycle.
- Valid/ready handshake on both sides, whole-pipe stall under backpressure, and a divide-by-zero flag.
- Replaces the fixed-constant reciprocal pipeline in the arithmetic path (dividend becomes a run-time input).

Parameters:
- N, 8, dividend and quotient width in bits (N >= 2).
- M, 4, divisor and remainder width in bits (2 <= M <= N).
- TAG_W, 4, width of user tag carried alongside each operation (used only with DIVIDER_PIPE_TAG_EN).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  pipe can accept this cycle.
- dividend  input  N  unsigned dividend.
- divisor  input  M  unsigned divisor.
- in_tag  input  TAG_W  user tag (present only with DIVIDER_PIPE_TAG_EN).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  M  unsigned remainder.
- div_zero  output  1  result came from divisor == 0.
- out_tag  output  TAG_W  tag of the result (present only with DIVIDER_PIPE_TAG_EN).

Behaviour:
- Reset:
  - On a clk edge with rstn=0, every stage valid bit clears. Data registers may keep their values.
  - Outputs after reset: out_valid=0, quotient=0, remainder=0, div_zero=0, out_tag=0, in_ready=1.
  - Reset asserted mid-operation discards all in-flight operations; nothing is emitted afterwards.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stalled, no stage register changes. Outputs are held stable.
- Accept and latency:
  - An operation is accepted on an edge where in_valid & in_ready.
  - Stage 0 captures the operands together with a partial remainder of M+1 bits set to 0.
  - With no stall, the result appears N edges after acceptance. Result is on registered outputs; out_valid is high in the cycle after the N-th edge.
  - Each stall cycle adds one cycle of latency.
- Stage i (i = 0..N-1), restoring step:
  - t = {partial_rem[M-1:0], dividend bit N-1-i}, width M+1.
  - If t >= {1'b0, divisor}: new partial = t - divisor and quotient bit N-1-i = 1.
  - Otherwise: new partial = t and the quotient bit = 0.
  - Divisor, dividend and the zero flag travel with the operation.
  - Bubble (valid=0) stages still shift; their data is don't-care.
- Throughput:
  - One result per cycle with out_ready=1 and back-to-back in_valid.
  - Results come out in acceptance order. No drops, no duplicates.
  - Simultaneous accept and output in the same cycle is legal.
- Divide by zero:
  - div_zero is registered at stage 0 as (divisor == 0) and carried down the pipe.
  - At the output: quotient = all ones (2^N - 1), remainder = 0, div_zero = 1.
  - Throughput and latency are unchanged.
- Width rules:
  - quotient < 2^N always.
  - remainder < divisor when divisor != 0.
  - dividend = quotient*divisor + remainder (exact, unsigned).
- Outputs are fully registered. The only combinational input-to-output path is out_ready -> in_ready.

Optional Feature:
- Macro: DIVIDER_PIPE_TAG_EN.
- When defined: in_tag and out_tag ports exist. The tag is registered with each operation and emerges unchanged with its result. out_tag resets to 0.
- When undefined: the tag ports and tag registers are absent. All other behaviour is identical.

Test Plan:
- N=8, M=4. Reset, then dividend=200, divisor=7, single op -> after 8 cycles: out_valid=1 for one cycle, quotient=28, remainder=4, div_zero=0.
- Boundary operands: 255/1 -> q=255, r=0. 0/15 -> q=0, r=0. 14/15 -> q=0, r=14. 255/15 -> q=17, r=0.
- Divide by zero: 5/0 -> q=255, r=0, div_zero=1. The next op 9/3 follows one cycle later -> q=3, r=0, div_zero=0.
- Streaming: 16 back-to-back random ops with out_ready=1 -> 16 consecutive out_valid cycles starting 8 cycles after the first accept. All match the reference model, in order. With tags 0..15, out_tag follows 0..15.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, outputs stable, no loss. Release -> stream resumes in order with a total delay of 3 cycles.
- Reset mid-pipe: accept 4 ops, assert rstn=0 for 1 edge -> out_valid=0, in_ready=1 next cycle, none of the 4 results ever appear. A fresh 100/9 then yields q=11, r=1.

Source files
------------

// File: rtl/divider_pipe.sv
// divider_pipe: fully pipelined unsigned restoring divider, one quotient bit per stage.
// Define DIVIDER_PIPE_TAG_EN to carry a user tag (in_tag/out_tag) alongside each operation.
module divider_pipe #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     dividend,
    input  logic [M-1:0]     divisor,
`ifdef DIVIDER_PIPE_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     quotient,
    output logic [M-1:0]     remainder,
    output logic             div_zero
);

    if (N < 2 || M < 2 || M > N || TAG_W < 1) begin : g_param_check
        $error("divider_pipe: illegal parameter combination");
    end

    logic         stall;

    // dq holds unconsumed dividend bits in the MSBs and resolved quotient bits in the LSBs.
    logic [N-1:0] vld_q, vld_d;
    logic [N-1:0] zero_q, zero_d;
    logic [N-1:0] dq_q  [N];
    logic [N-1:0] dq_d  [N];
    logic [M-1:0] dvs_q [N];
    logic [M-1:0] dvs_d [N];
    logic [M-1:0] rem_q [N];
    logic [M-1:0] rem_d [N];

    logic [M:0]   step_t   [N];
    logic [M-1:0] step_rem [N];
    logic [N-1:0] step_dq  [N];

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [M-1:0] remainder_q, remainder_d;
    logic         div_zero_q, div_zero_d;

    // Restoring step for every stage.
    always_comb begin
        for (int s = 0; s < N; s++) begin
            step_t[s]  = {rem_q[s], dq_q[s][N-1]};
            step_dq[s] = {dq_q[s][N-2:0], 1'b0};
            if (step_t[s] >= {1'b0, dvs_q[s]}) begin
                // The difference is below the divisor, so its low M bits are exact.
                step_rem[s]   = step_t[s][M-1:0] - dvs_q[s];
                step_dq[s][0] = 1'b1;
            end else begin
                step_rem[s] = step_t[s][M-1:0];
            end
        end
    end

    // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        stall    = out_valid_q & ~out_ready;
        in_ready = ~stall;

        vld_d[0]  = in_valid & in_ready;
        zero_d[0] = (divisor == '0);
        dq_d[0]   = dividend;
        dvs_d[0]  = divisor;
        rem_d[0]  = '0;
        for (int s = 1; s < N; s++) begin
            vld_d[s]  = vld_q[s-1];
            zero_d[s] = zero_q[s-1];
            dq_d[s]   = step_dq[s-1];
            dvs_d[s]  = dvs_q[s-1];
            rem_d[s]  = step_rem[s-1];
        end

        out_valid_d = vld_q[N-1];
        div_zero_d  = zero_q[N-1];
        quotient_d  = zero_q[N-1] ? '1 : step_dq[N-1];
        remainder_d = zero_q[N-1] ? '0 : step_rem[N-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else if (!stall) begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    // NOTE: stage data arrays are left unreset; the valid bits alone decide what is meaningful.
    always_ff @(posedge clk) begin
        if (!stall) begin
            zero_q <= zero_d;
            dq_q   <= dq_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

`ifdef DIVIDER_PIPE_TAG_EN
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    always_comb begin
        tag_d[0] = in_tag;
        for (int s = 1; s < N; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        out_tag_d = tag_q[N-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_tag_q <= '0;
        end else if (!stall) begin
            out_tag_q <= out_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            tag_q <= tag_d;
        end
    end

    assign out_tag = out_tag_q;
`endif

endmodule
